// File: rtl/tc_pkg.sv
// Shared types, lamp encodings and phase-duration lookup for the traffic controller.
// Optional feature macro: TC_ALL_RED_EN (adds the AR1/AR2 all-red phases).
package tc_pkg;

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   typedef enum logic [2:0] {
      S1 = 3'd0,
      S2 = 3'd1,
      S3 = 3'd2,
      S4 = 3'd3,
      S5 = 3'd4,
`ifdef TC_ALL_RED_EN
      S6  = 3'd5,
      AR1 = 3'd6,
      AR2 = 3'd7
`else
      S6 = 3'd5
`endif
   } phase_t;

   function automatic int unsigned phase_dur(input phase_t p,
                                             input int unsigned t_main,
                                             input int unsigned t_yel,
                                             input int unsigned t_turn,
                                             input int unsigned t_side,
                                             input int unsigned t_allred);
      int unsigned d;
      d = t_main;
      case (p)
         S1:         d = t_main;
         S2, S4, S6: d = t_yel;
         S3:         d = t_turn;
         S5:         d = t_side;
`ifdef TC_ALL_RED_EN
         AR1, AR2:   d = t_allred;
`endif
         default:    d = t_main;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/tc_phase_timer.sv
// Phase cycle counter: counts clocks in the current phase, flags the last cycle,
// and restarts from zero whenever the controller loads a new phase.
module tc_phase_timer #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] dur,
   output logic             done
);

   logic [CNT_W-1:0] cnt;

   assign done = (cnt == dur - CNT_W'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/traffic_controller.sv
// Fixed-time four-signal intersection controller: Moore FSM over a 6-phase cycle.
// Define TC_ALL_RED_EN to insert an all-red phase after S4 and after S6.
module traffic_controller
   import tc_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC = 1,
   parameter int unsigned T_MAIN        = 7,
   parameter int unsigned T_YEL         = 2,
   parameter int unsigned T_TURN        = 5,
   parameter int unsigned T_SIDE        = 3,
   parameter int unsigned T_ALLRED      = 1
) (
   input  logic       clk,
   input  logic       rst,
   output logic [2:0] light_M1,
   output logic [2:0] light_Mt,
   output logic [2:0] light_M2,
   output logic [2:0] light_S
);

   localparam int unsigned MAX_A   = (T_MAIN > T_YEL)   ? T_MAIN : T_YEL;
   localparam int unsigned MAX_B   = (T_TURN > T_SIDE)  ? T_TURN : T_SIDE;
   localparam int unsigned MAX_AB  = (MAX_A > MAX_B)    ? MAX_A  : MAX_B;
   localparam int unsigned MAX_DUR = (MAX_AB > T_ALLRED) ? MAX_AB : T_ALLRED;
   localparam int unsigned CNT_W   = $clog2(MAX_DUR * TICKS_PER_SEC + 1);

   phase_t           state;
   phase_t           state_nxt;
   logic             done;
   logic             load;
   logic [CNT_W-1:0] dur_cycles;

   always_comb begin
      dur_cycles = CNT_W'(phase_dur(state, T_MAIN, T_YEL, T_TURN, T_SIDE, T_ALLRED)
                          * TICKS_PER_SEC);
   end

   // Any phase change, including recovery from a stray encoding, restarts the timer.
   assign load = (state_nxt != state);

   tc_phase_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .dur  (dur_cycles),
      .done (done)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S1;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S1: if (done) state_nxt = S2;
         S2: if (done) state_nxt = S3;
         S3: if (done) state_nxt = S4;
`ifdef TC_ALL_RED_EN
         S4:  if (done) state_nxt = AR1;
         AR1: if (done) state_nxt = S5;
         S5:  if (done) state_nxt = S6;
         S6:  if (done) state_nxt = AR2;
         AR2: if (done) state_nxt = S1;
`else
         S4: if (done) state_nxt = S5;
         S5: if (done) state_nxt = S6;
         S6: if (done) state_nxt = S1;
`endif
         default: state_nxt = S1;
      endcase
   end

   // Lamps depend on the state register alone; everything not driven green/yellow is red.
   always_comb begin
      light_M1 = RED;
      light_Mt = RED;
      light_M2 = RED;
      light_S  = RED;
      case (state)
         S1: begin
            light_M1 = GRN;
            light_M2 = GRN;
         end
         S2: begin
            light_M1 = GRN;
            light_M2 = YEL;
         end
         S3: begin
            light_M1 = GRN;
            light_Mt = GRN;
         end
         S4: begin
            light_M1 = YEL;
            light_Mt = YEL;
         end
         S5: light_S = GRN;
         S6: light_S = YEL;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_traffic_controller.sv
// Scoreboard bench for traffic_controller: driver queues expected lamps per clock,
// monitor pops and compares on the falling edge and checks lamp safety every cycle.
module tb_traffic_controller;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] light_M1;
   logic [2:0] light_Mt;
   logic [2:0] light_M2;
   logic [2:0] light_S;

   int checks = 0;
   int errors = 0;

   logic [11:0] exp_q[$];
   logic [11:0] cyc[$];
   int          s5_idx;
   int          imm_kind = 0;
   logic [11:0] imm_exp  = '0;
   event        imm_ev;

   always #5 clk = ~clk;

   traffic_controller dut (
      .clk      (clk),
      .rst      (rst),
      .light_M1 (light_M1),
      .light_Mt (light_Mt),
      .light_M2 (light_M2),
      .light_S  (light_S)
   );

   task automatic add_phase(input logic [11:0] lamps, input int n);
      for (int i = 0; i < n; i++) cyc.push_back(lamps);
   endtask

   // Hand-written phase table: {M1,Mt,M2,S} and duration in cycles (TPS=1).
   task automatic build_cycle();
      add_phase({G, R, G, R}, 7);
      add_phase({G, R, Y, R}, 2);
      add_phase({G, G, R, R}, 5);
      add_phase({Y, Y, R, R}, 2);
`ifdef TC_ALL_RED_EN
      add_phase({R, R, R, R}, 1);
`endif
      s5_idx = cyc.size();
      add_phase({R, R, R, G}, 3);
      add_phase({R, R, R, Y}, 2);
`ifdef TC_ALL_RED_EN
      add_phase({R, R, R, R}, 1);
`endif
   endtask

   // Monitor: sole owner of the check/error counters.
   initial begin
      logic [11:0] e;
      logic [11:0] got;
      forever begin
         @(negedge clk or imm_ev);
         got = {light_M1, light_Mt, light_M2, light_S};
         if (imm_kind == 1) begin
            checks++;
            if (got !== imm_exp) begin
               errors++;
               $display("FAIL async_reset: got %b required %b at %0t", got, imm_exp, $time);
            end
         end else if (imm_kind == 2) begin
            checks++;
            if (exp_q.size() != 0) begin
               errors++;
               $display("FAIL drain: %0d entries left, required 0", exp_q.size());
            end
         end else begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               checks++;
               if (got !== e) begin
                  errors++;
                  $display("FAIL lamps: got %b required %b at %0t", got, e, $time);
               end
            end
            if (rst) begin
               checks++;
               if (!($onehot(light_M1) && $onehot(light_Mt) &&
                     $onehot(light_M2) && $onehot(light_S))) begin
                  errors++;
                  $display("FAIL onehot: got %b required one-hot per lamp at %0t", got, $time);
               end
               checks++;
               if ((light_S == G && (light_M1 != R || light_Mt != R || light_M2 != R)) ||
                   (light_Mt == G && light_M2 != R)) begin
                  errors++;
                  $display("FAIL conflict: got %b required no conflicting greens at %0t",
                           got, $time);
               end
            end
         end
      end
   end

   task automatic request(input int kind, input logic [11:0] e);
      imm_exp  = e;
      imm_kind = kind;
      ->imm_ev;
      #1;
      imm_kind = 0;
   endtask

   initial begin
      int len;
      build_cycle();
      len = cyc.size();

      // Asynchronous reset must show S1 lamps without any clock edge.
      #2 rst = 1'b0;
      #1 request(1, {G, R, G, R});
      @(negedge clk);
      rst = 1'b1;

      // Three full cycles from release; after edge n the lamps are cyc[n % len].
      for (int n = 1; n <= 3 * len; n++) begin
         @(posedge clk);
         exp_q.push_back(cyc[n % len]);
      end

      // Run into the middle of S5, then pulse reset.
      for (int n = 1; n <= s5_idx + 1; n++) begin
         @(posedge clk);
         exp_q.push_back(cyc[n % len]);
      end
      @(negedge clk);
      #1 rst = 1'b0;
      #1 request(1, {G, R, G, R});
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      // After the pulse S1 must run its full length and the cycle repeat.
      for (int n = 1; n <= len + 2; n++) begin
         @(posedge clk);
         exp_q.push_back(cyc[n % len]);
      end
      @(negedge clk);
      #2 request(2, '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
